instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Bus initiator for the byte-wide, read-only instruction memory.
//  - Owns the program counter (PC) and drives the memory address.
//  - Reads the 4 bytes of each 32-bit instruction, assembles them
//    little-endian, and hands the word to the control unit with valid/ready.
//  - Accepts branch redirects from the control unit.
// PARAMETERS
//  WORD_SIZE  32  instruction/PC width; fixed at 4 bytes of 8 bits
//  MEM_DEPTH  64  instruction memory depth in bytes; power of 2, >=8
//  ADDR_W     $clog2(MEM_DEPTH)  memory address width
//  RESET_PC   0   PC after reset; multiple of 4, < MEM_DEPTH
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          asynchronous, active-high reset
//  mem_addr       out  ADDR_W     byte address to instruction memory
//  mem_rdata      in   8          memory read data; registered, valid 1 cycle after mem_addr
//  instr          out  WORD_SIZE  assembled instruction
//  instr_valid    out  1          instr holds a complete instruction
//  instr_ready    in   1          control unit accepts instr
//  pc_out         out  WORD_SIZE  byte address of instr (zero-extended PC)
//  branch_en      in   1          redirect request, single-cycle pulse
//  branch_target  in   WORD_SIZE  redirect address; low ADDR_W bits used
//  fetch_fault    out  1          misaligned-branch fault; see CONFIGURATION
// BEHAVIOUR
//  Reset values (async): PC=RESET_PC, mem_addr=RESET_PC, instr=0, instr_valid=0,
//   pc_out=RESET_PC, fetch_fault=0, state=FETCH, issue_cnt=0, cap_cnt=0.
//  States:
//   FETCH: mem_addr=PC+issue_cnt.
//    - issue_cnt counts 0..3, one step per cycle, then holds.
//    - cap_cnt captures mem_rdata into byte lane cap_cnt, one cycle behind the
//      memory. Byte at PC goes to instr[7:0]; byte at PC+3 goes to instr[31:24].
//    - When lane 3 is captured: instr_valid<=1 and state<=HOLD.
//   HOLD: instr, pc_out and mem_addr stable. On instr_valid&&instr_ready:
//    instr_valid<=0, PC<=PC+4, issue_cnt=cap_cnt=0, state<=FETCH.
//   FAULT: present only with the macro enabled; see CONFIGURATION.
//  Latency:
//   - First byte address appears at cycle N; instr_valid is high from cycle N+5.
//   - Throughput: 1 instruction per 6 cycles when instr_ready is held high.
//  Handshake:
//   - instr and pc_out do not change while instr_valid=1 and instr_ready=0.
//   - instr_valid never drops without a handshake, except on a branch or reset.
//  Branch (any state, highest priority):
//   - Partial bytes are discarded, instr_valid<=0, PC<=branch_target.
//   - FETCH restarts next cycle with issue_cnt=0.
//   - Handshake in the same cycle as a branch: the word counts as consumed and
//     PC takes branch_target, not PC+4.
//  Arithmetic: all address math is modulo MEM_DEPTH (ADDR_W bits).
//   - PC=MEM_DEPTH-4 advances to 0.
//   - PC+issue_cnt wraps.
//   - Upper bits of branch_target are ignored.
//  Reset mid-fetch: abort immediately; after reset is released, fetch restarts at RESET_PC.
// CONFIGURATION
//  Macro IFU_MISALIGN_CHECK_EN:
//   - Defined: a branch with branch_target[1:0]!=0 forces state FAULT.
//     In FAULT: fetch_fault=1, instr_valid=0, mem_addr holds, branch_en is
//     ignored. Only rst exits FAULT.
//   - Undefined: branch_target[1:0] is used as-is (unaligned fetch allowed).
//     fetch_fault is tied to 0 and the FAULT state is not built.
// STRUCTURE
//  Package fetch_pkg:
//   - typedef enum {FETCH, HOLD, FAULT} fetch_state_t
//   - INSTR_BYTES=4, BYTE_W=8
//   - localparam lane-index constants
//  Sub-module instr_byte_assembler:
//   - 4x8 lane register with a lane-select write strobe.
//   - Lane clear on branch or handshake.
//   - Full flag when lane 3 is written.
//  Top level: FSM, PC register, issue/capture counters.
// TESTING
//  Bench models a byte memory with registered read (1-cycle latency); memory is
//  preloaded with bytes 00..3F (data = address).
//  1 Reset release, instr_ready=1 -> first instr=32'h03020100 with pc_out=0
//    at cycle 5; next instr=32'h07060504 with pc_out=4.
//  2 instr_ready=0 for 10 cycles after valid -> instr, pc_out and mem_addr stable;
//    a single handshake follows, then PC=4.
//  3 branch_en with target=0x20 during issue_cnt=2 -> no valid for the partial
//    word; next instr=32'h23222120 with pc_out=0x20.
//  4 Branch to 0x3C, ready=1 -> instr=32'h3F3E3D3C, then wrap: instr=32'h03020100
//    with pc_out=0.
//  5 Handshake and branch_en (target 0x10) in the same cycle -> next pc_out=0x10,
//    not PC+4.
//  6 With IFU_MISALIGN_CHECK_EN, branch to 0x11 -> fetch_fault=1, instr_valid=0;
//    a later branch is ignored; rst clears the fault. Without the macro ->
//    instr=32'h14131211.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned LANE_W      = $clog2(INSTR_BYTES);

  // Byte-lane indices inside an instruction word (lane 0 = lowest address).
  localparam logic [LANE_W-1:0] LANE0 = LANE_W'(0);
  localparam logic [LANE_W-1:0] LANE1 = LANE_W'(1);
  localparam logic [LANE_W-1:0] LANE2 = LANE_W'(2);
  localparam logic [LANE_W-1:0] LANE3 = LANE_W'(3);

  // Increment a lane index, saturating at the last lane.
  function automatic logic [LANE_W-1:0] lane_sat_inc(input logic [LANE_W-1:0] lane);
    return (lane == LANE3) ? LANE3 : lane + LANE_W'(1);
  endfunction

endpackage

// File: rtl/instr_byte_assembler.sv
// instr_byte_assembler: collects four bytes into one little-endian word.
module instr_byte_assembler
  import fetch_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [LANE_W-1:0]             lane_sel,
  input  logic [BYTE_W-1:0]             wr_data,
  input  logic                          clr,
  output logic [INSTR_BYTES*BYTE_W-1:0] data,
  output logic                          full
);

  logic [INSTR_BYTES-1:0][BYTE_W-1:0] lanes;

  assign data = lanes;

  // Lane storage; clear wins over a write so a redirect never keeps stale bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes <= '0;
      full  <= 1'b0;
    end else if (clr) begin
      lanes <= '0;
      full  <= 1'b0;
    end else if (wr_en) begin
      lanes[lane_sel] <= wr_data;
      if (lane_sel == LANE3) begin
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: byte-serial fetch from a registered-read instruction
// memory, with PC ownership, valid/ready delivery and branch redirect.
// Optional build macro IFU_MISALIGN_CHECK_EN: a branch to a non-word-aligned
// target locks the unit in FAULT until reset.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH),
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [BYTE_W-1:0]    mem_rdata,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] pc_out,
  input  logic                 branch_en,
  input  logic [WORD_SIZE-1:0] branch_target,
  output logic                 fetch_fault
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [LANE_W-1:0] issue_cnt;
  logic [LANE_W-1:0] cap_cnt;
  logic              data_valid_q;

  logic handshake_c;
  logic branch_take_c;
  logic redirect_c;
  logic capture_c;
  logic last_c;
  logic lane_clr_c;
  logic unused_tgt_hi;

  // Only the low address bits of a branch target are meaningful.
  assign unused_tgt_hi = ^branch_target[WORD_SIZE-1:ADDR_W];

  assign handshake_c = instr_valid && instr_ready;

`ifdef IFU_MISALIGN_CHECK_EN
  logic enter_fault_c;
  logic fault_q;

  assign branch_take_c = branch_en && (state_q != FAULT);
  assign enter_fault_c = branch_take_c && (branch_target[1:0] != 2'b00);
  assign redirect_c    = branch_take_c && !enter_fault_c;
  assign fetch_fault   = fault_q;

  // Sticky fault flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (enter_fault_c) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign branch_take_c = branch_en;
  assign redirect_c    = branch_take_c;
  assign fetch_fault   = 1'b0;
`endif

  // Memory data is one cycle behind the address; data_valid_q marks a real byte.
  assign capture_c  = (state_q == FETCH) && data_valid_q && !branch_take_c;
  assign last_c     = capture_c && (cap_cnt == LANE3);
  assign lane_clr_c = branch_take_c || handshake_c;

  instr_byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (capture_c),
    .lane_sel (cap_cnt),
    .wr_data  (mem_rdata),
    .clr      (lane_clr_c),
    .data     (instr),
    .full     (instr_valid)
  );

  // Fetch FSM with PC, address and issue/capture counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= ADDR_W'(RESET_PC);
      mem_addr     <= ADDR_W'(RESET_PC);
      pc_out       <= WORD_SIZE'(RESET_PC);
      issue_cnt    <= LANE0;
      cap_cnt      <= LANE0;
      data_valid_q <= 1'b0;
    end else begin
`ifdef IFU_MISALIGN_CHECK_EN
      if (enter_fault_c) begin
        state_q      <= FAULT;
        data_valid_q <= 1'b0;
      end else
`endif
      if (redirect_c) begin
        state_q      <= FETCH;
        pc_q         <= branch_target[ADDR_W-1:0];
        mem_addr     <= branch_target[ADDR_W-1:0];
        issue_cnt    <= LANE0;
        cap_cnt      <= LANE0;
        data_valid_q <= 1'b0;
      end else begin
        case (state_q)
          FETCH: begin
            issue_cnt    <= lane_sat_inc(issue_cnt);
            mem_addr     <= pc_q + ADDR_W'(lane_sat_inc(issue_cnt));
            data_valid_q <= !last_c;
            if (capture_c) begin
              cap_cnt <= cap_cnt + LANE_W'(1);
            end
            if (last_c) begin
              state_q <= HOLD;
              pc_out  <= WORD_SIZE'(pc_q);
            end
          end
          HOLD: begin
            if (handshake_c) begin
              state_q      <= FETCH;
              pc_q         <= pc_q + ADDR_W'(INSTR_BYTES);
              mem_addr     <= pc_q + ADDR_W'(INSTR_BYTES);
              issue_cnt    <= LANE0;
              cap_cnt      <= LANE0;
              data_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

endmodule
